// File: rtl/rc4_ksa_top.sv
// RC4 key-scheduling board top: fills S[i]=i, then permutes S with a key latched from SW.
// Optional build macro KSA_READBACK_EN adds rb_addr/rb_data to read S once scheduling is done.
module rc4_ksa_top #(
    parameter int KEY_BYTES = 3,
    parameter int MEM_DEPTH = 256
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic [9:0] SW,
    output logic [9:0] LEDR,
    output logic [6:0] HEX0,
    output logic [6:0] HEX1,
    output logic [6:0] HEX2,
    output logic [6:0] HEX3,
    output logic [6:0] HEX4,
    output logic [6:0] HEX5
`ifdef KSA_READBACK_EN
    ,
    input  logic [7:0] rb_addr,
    output logic [7:0] rb_data
`endif
);

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_RD_I   = 4'd1,
        ST_WAIT_I = 4'd2,
        ST_CALC   = 4'd3,
        ST_RD_J   = 4'd4,
        ST_WAIT_J = 4'd5,
        ST_WR_I   = 4'd6,
        ST_WR_J   = 4'd7,
        ST_DONE   = 4'd8
    } state_t;

    localparam logic [1:0] KIDX_LAST = 2'(KEY_BYTES - 1);

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'h0:    s = 7'h40;
            4'h1:    s = 7'h79;
            4'h2:    s = 7'h24;
            4'h3:    s = 7'h30;
            4'h4:    s = 7'h19;
            4'h5:    s = 7'h12;
            4'h6:    s = 7'h02;
            4'h7:    s = 7'h78;
            4'h8:    s = 7'h00;
            4'h9:    s = 7'h10;
            4'hA:    s = 7'h08;
            4'hB:    s = 7'h03;
            4'hC:    s = 7'h46;
            4'hD:    s = 7'h21;
            4'hE:    s = 7'h06;
            4'hF:    s = 7'h0E;
            default: s = 7'h7F;
        endcase
        return s;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [7:0]  i_r, j_r, si_r;
    logic [1:0]  kidx_r;
    logic [23:0] key_r, key_nxt_s;
    logic        latched_r;
    logic [9:0]  led_r;
    logic [41:0] hex_r;
    logic [7:0]  kbyte_s;
    logic        mem_we_s;
    logic [7:0]  mem_addr_s, mem_wdata_s, rdata_r;
    logic [7:0]  mem_r [0:MEM_DEPTH-1];
    logic        unused_s;

    assign unused_s  = ^KEY;
    assign key_nxt_s = latched_r ? key_r : {14'b0, SW};
    assign LEDR = led_r;
    assign HEX0 = hex_r[6:0];
    assign HEX1 = hex_r[13:7];
    assign HEX2 = hex_r[20:14];
    assign HEX3 = hex_r[27:21];
    assign HEX4 = hex_r[34:28];
    assign HEX5 = hex_r[41:35];

    // Key byte selection: byte 0 is the most significant key byte.
    always_comb begin
        kbyte_s = key_r[7:0];
        case (kidx_r)
            2'd0:    kbyte_s = key_r[23:16];
            2'd1:    kbyte_s = key_r[15:8];
            default: kbyte_s = key_r[7:0];
        endcase
    end

    // FSM next state and memory port control.
    always_comb begin
        state_nxt_s = state_r;
        mem_we_s    = 1'b0;
        mem_addr_s  = i_r;
        mem_wdata_s = i_r;
        case (state_r)
            ST_INIT: begin
                mem_we_s = 1'b1;
                if (i_r == 8'hFF) state_nxt_s = ST_RD_I;
                else              state_nxt_s = ST_INIT;
            end
            ST_RD_I:   state_nxt_s = ST_WAIT_I;
            ST_WAIT_I: state_nxt_s = ST_CALC;
            ST_CALC:   state_nxt_s = ST_RD_J;
            ST_RD_J: begin
                mem_addr_s  = j_r;
                state_nxt_s = ST_WAIT_J;
            end
            ST_WAIT_J: begin
                mem_addr_s  = j_r;
                state_nxt_s = ST_WR_I;
            end
            ST_WR_I: begin
                // rdata_r still holds S[j] from the read issued in RD_J/WAIT_J
                mem_we_s    = 1'b1;
                mem_wdata_s = rdata_r;
                state_nxt_s = ST_WR_J;
            end
            ST_WR_J: begin
                mem_we_s    = 1'b1;
                mem_addr_s  = j_r;
                mem_wdata_s = si_r;
                if (i_r == 8'hFF) state_nxt_s = ST_DONE;
                else              state_nxt_s = ST_RD_I;
            end
            ST_DONE: begin
`ifdef KSA_READBACK_EN
                mem_addr_s = rb_addr;
`else
                mem_addr_s = i_r;
`endif
                state_nxt_s = ST_DONE;
            end
            default: state_nxt_s = ST_INIT;
        endcase
    end

    // State register, key latch and registered LED/7-seg outputs.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            state_r   <= ST_INIT;
            key_r     <= 24'h000000;
            latched_r <= 1'b0;
            led_r     <= 10'b0;
            hex_r     <= {6{7'h40}};
        end else begin
            state_r   <= state_nxt_s;
            key_r     <= key_nxt_s;
            latched_r <= 1'b1;
            led_r     <= {8'b0, state_nxt_s != ST_DONE, state_nxt_s == ST_DONE};
            for (int n = 0; n < 6; n++) begin
                hex_r[7*n +: 7] <= seg7(key_nxt_s[4*n +: 4]);
            end
        end
    end

    // KSA datapath: indices, key-byte index and saved S[i].
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            i_r    <= 8'h00;
            j_r    <= 8'h00;
            si_r   <= 8'h00;
            kidx_r <= 2'd0;
        end else begin
            case (state_r)
                ST_INIT: begin
                    if (i_r == 8'hFF) begin
                        i_r    <= 8'h00;
                        j_r    <= 8'h00;
                        kidx_r <= 2'd0;
                    end else begin
                        i_r <= i_r + 8'd1;
                    end
                end
                ST_CALC: begin
                    si_r <= rdata_r;
                    j_r  <= j_r + rdata_r + kbyte_s;
                end
                ST_WR_J: begin
                    if (i_r != 8'hFF) begin
                        i_r    <= i_r + 8'd1;
                        kidx_r <= (kidx_r == KIDX_LAST) ? 2'd0 : kidx_r + 2'd1;
                    end else begin
                        i_r <= i_r;
                    end
                end
                default: i_r <= i_r;
            endcase
        end
    end

    // Single-port state memory, synchronous write, one-cycle registered read.
    always_ff @(posedge CLOCK_50) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= mem_wdata_s;
        end
        rdata_r <= mem_r[mem_addr_s];
    end

`ifdef KSA_READBACK_EN
    assign rb_data = (state_r == ST_DONE) ? rdata_r : 8'h00;
`endif

endmodule

// File: tb/tb_rc4_ksa_top.sv
// Directed bench for rc4_ksa_top: key latch, 7-seg digits, LEDR timing, mid-run reset and final S.
module tb_rc4_ksa_top;

    logic       CLOCK_50 = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] KEY = 4'hF;
    logic [9:0] SW = 10'h000;
    logic [9:0] LEDR;
    logic [6:0] HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
`ifdef KSA_READBACK_EN
    logic [7:0] rb_addr = 8'h00;
    logic [7:0] rb_data;
`endif

    int tests_run = 0;
    int tests_failed = 0;
    logic [7:0] exp_s [0:255];

    rc4_ksa_top dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .KEY(KEY), .SW(SW), .LEDR(LEDR),
        .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
`ifdef KSA_READBACK_EN
        , .rb_addr(rb_addr), .rb_data(rb_data)
`endif
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each call advances n rising edges; the bench drives and samples on falling edges.
    task automatic cyc(input int n);
        repeat (n) @(negedge CLOCK_50);
    endtask

    task automatic ksa_model(input logic [7:0] k0, input logic [7:0] k1, input logic [7:0] k2);
        logic [7:0] jj, t, kb;
        for (int i = 0; i < 256; i++) exp_s[i] = 8'(i);
        jj = 8'h00;
        for (int i = 0; i < 256; i++) begin
            kb = (i % 3 == 0) ? k0 : ((i % 3 == 1) ? k1 : k2);
            jj = jj + exp_s[i] + kb;
            t = exp_s[i];
            exp_s[i] = exp_s[jj];
            exp_s[jj] = t;
        end
    endtask

    // Releases reset and follows one complete schedule through DONE and the final S check.
    task automatic full_run(input logic [9:0] sw_late, input logic [41:0] hex_exp,
                            input logic [7:0] k1, input logic [7:0] k2);
        int bad;
        int nseen;
        logic seen [0:255];
        logic [7:0] v;
        reset = 1'b0;
        cyc(1);
        chk("busy_first", {54'b0, LEDR}, 64'h002);
        chk("hex_latched", {22'b0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'b0, hex_exp});
`ifdef KSA_READBACK_EN
        chk("rb_idle_zero", {56'b0, rb_data}, 64'h0);
`endif
        bad = 0;
        for (int c = 2; c <= 2047; c++) begin
            if (c == 100) SW = sw_late;
            cyc(1);
            if (LEDR !== 10'h002) bad++;
        end
        chk("no_early_done", 64'(bad), 64'd0);
        chk("busy_2047", {54'b0, LEDR}, 64'h002);
        cyc(1);
        chk("done_2048", {54'b0, LEDR}, 64'h001);
        chk("hex_hold", {22'b0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'b0, hex_exp});
        ksa_model(8'h00, k1, k2);
        bad = 0;
        nseen = 0;
        for (int k = 0; k < 256; k++) seen[k] = 1'b0;
        for (int k = 0; k < 256; k++) begin
            v = dut.mem_r[k];
            if (v !== exp_s[k]) bad++;
            if (!seen[v]) nseen++;
            seen[v] = 1'b1;
        end
        chk("s_match_model", 64'(bad), 64'd0);
        chk("s_permutation", 64'(nseen), 64'd256);
`ifdef KSA_READBACK_EN
        bad = 0;
        for (int k = 0; k < 256; k++) begin
            rb_addr = 8'(k);
            cyc(1);
            if (rb_data !== exp_s[k]) bad++;
        end
        chk("rb_match_model", 64'(bad), 64'd0);
`endif
        cyc(5);
        chk("done_hold", {54'b0, LEDR}, 64'h001);
    endtask

    initial begin
        // Run 1: key 0x249, SW changed mid-run must be ignored.
        reset = 1'b1;
        SW = 10'h249;
        cyc(2);
        chk("reset_ledr", {54'b0, LEDR}, 64'h0);
        chk("reset_hex", {22'b0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'b0, {6{7'h40}}});
        full_run(10'h3FF, {7'h40, 7'h40, 7'h40, 7'h24, 7'h19, 7'h10}, 8'h02, 8'h49);

        // Run 2: reset reasserted at cycle 500, restart with SW=0.
        reset = 1'b1;
        SW = 10'h249;
        cyc(1);
        reset = 1'b0;
        cyc(500);
        chk("midrun_busy", {54'b0, LEDR}, 64'h002);
        reset = 1'b1;
        SW = 10'h000;
        cyc(1);
        chk("midrun_reset_ledr", {54'b0, LEDR}, 64'h0);
        chk("midrun_reset_hex", {22'b0, HEX5, HEX4, HEX3, HEX2, HEX1, HEX0}, {22'b0, {6{7'h40}}});
        full_run(10'h000, {6{7'h40}}, 8'h00, 8'h00);

        // Run 3: key 0x3A5 exercises digits 3, A, 5 and a different key schedule.
        reset = 1'b1;
        SW = 10'h3A5;
        cyc(2);
        full_run(10'h3A5, {7'h40, 7'h40, 7'h40, 7'h30, 7'h08, 7'h12}, 8'h03, 8'hA5);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
